// File: rtl/axi_error_slave_if.sv
// AXI4 channel bundle between one master and one slave; widths are parameters.
// Latency: none, this is wiring only.
// Backpressure: plain valid/ready on each of the five channels.
// Ports: clk, rstn are carried so that both ends share one clock/reset net.
interface axi_channel #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int USER_WIDTH = 1
) (
  input logic clk,
  input logic rstn
);
  // Write address
  logic [ID_WIDTH-1:0]     aw_id;
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic [7:0]              aw_len;
  logic [2:0]              aw_size;
  logic [1:0]              aw_burst;
  logic                    aw_lock;
  logic [3:0]              aw_cache;
  logic [2:0]              aw_prot;
  logic [3:0]              aw_qos;
  logic [3:0]              aw_region;
  logic [USER_WIDTH-1:0]   aw_user;
  logic                    aw_valid;
  logic                    aw_ready;
  // Write data
  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    w_last;
  logic [USER_WIDTH-1:0]   w_user;
  logic                    w_valid;
  logic                    w_ready;
  // Write response
  logic [ID_WIDTH-1:0]     b_id;
  logic [1:0]              b_resp;
  logic [USER_WIDTH-1:0]   b_user;
  logic                    b_valid;
  logic                    b_ready;
  // Read address
  logic [ID_WIDTH-1:0]     ar_id;
  logic [ADDR_WIDTH-1:0]   ar_addr;
  logic [7:0]              ar_len;
  logic [2:0]              ar_size;
  logic [1:0]              ar_burst;
  logic                    ar_lock;
  logic [3:0]              ar_cache;
  logic [2:0]              ar_prot;
  logic [3:0]              ar_qos;
  logic [3:0]              ar_region;
  logic [USER_WIDTH-1:0]   ar_user;
  logic                    ar_valid;
  logic                    ar_ready;
  // Read data
  logic [ID_WIDTH-1:0]     r_id;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [1:0]              r_resp;
  logic                    r_last;
  logic [USER_WIDTH-1:0]   r_user;
  logic                    r_valid;
  logic                    r_ready;

  modport master (
    input  clk, rstn,
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport slave (
    input  clk, rstn,
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );
endinterface

// File: rtl/axi_error_slave.sv
// Terminating AXI responder: answers every AW/W/AR with a fixed error response and the original ID.
// Latency: AW@N, W@N+1, B@N+2; first R beat the cycle after AR, ar_len+1 beats per burst.
// Backpressure: B and R held stable until ready; AW/AR stalled while the matching path is busy.
// Ports: clk, rstn (async active-low); master = upstream AXI slave-side modport.
module axi_error_slave #(
  parameter logic [1:0]    RESP   = 2'b11,
  parameter logic [1023:0] R_DATA = '0
) (
  input logic       clk,
  input logic       rstn,
  axi_channel.slave master
);
  localparam int IW = master.ID_WIDTH;
  localparam int DW = master.DATA_WIDTH;

  typedef enum logic [1:0] {WR_ADDR, WR_DATA, WR_RESP} w_state_e;
  typedef enum logic       {RD_ADDR, RD_DATA}          r_state_e;

  w_state_e        w_state_q;
  logic [IW-1:0]   b_id_q;
  r_state_e        r_state_q;
  logic [IW-1:0]   r_id_q;
  logic [7:0]      r_cnt_q;

  // Write path: the burst ends on w_last only, aw_len is never consulted.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_state_q <= WR_ADDR;
      b_id_q    <= '0;
    end else begin
      unique case (w_state_q)
        WR_ADDR: if (master.aw_valid) begin
          b_id_q    <= master.aw_id;
          w_state_q <= WR_DATA;
        end
        WR_DATA: if (master.w_valid && master.w_last) w_state_q <= WR_RESP;
        WR_RESP: if (master.b_ready) w_state_q <= WR_ADDR;
        default: w_state_q <= WR_ADDR;
      endcase
    end
  end

  // Read path: counter holds beats remaining after the current one, so
  // ar_len=255 needs no ninth bit and last is simply counter==0.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state_q <= RD_ADDR;
      r_id_q    <= '0;
      r_cnt_q   <= '0;
    end else begin
      unique case (r_state_q)
        RD_ADDR: if (master.ar_valid) begin
          r_id_q    <= master.ar_id;
          r_cnt_q   <= master.ar_len;
          r_state_q <= RD_DATA;
        end
        RD_DATA: if (master.r_ready) begin
          if (r_cnt_q == 8'd0) r_state_q <= RD_ADDR;
          else                 r_cnt_q   <= r_cnt_q - 8'd1;
        end
        default: r_state_q <= RD_ADDR;
      endcase
    end
  end

  // All outputs are pure decodes of registered state; no valid->ready path.
  assign master.aw_ready = (w_state_q == WR_ADDR);
  assign master.w_ready  = (w_state_q == WR_DATA);
  assign master.b_valid  = (w_state_q == WR_RESP);
  assign master.b_id     = b_id_q;
  assign master.b_resp   = RESP;
  assign master.b_user   = '0;

  assign master.ar_ready = (r_state_q == RD_ADDR);
  assign master.r_valid  = (r_state_q == RD_DATA);
  assign master.r_id     = r_id_q;
  assign master.r_data   = R_DATA[DW-1:0];
  assign master.r_resp   = RESP;
  // Gated by state so the idle/reset value is 0 even though the counter is 0.
  assign master.r_last   = (r_state_q == RD_DATA) && (r_cnt_q == 8'd0);
  assign master.r_user   = '0;

  // Request attributes and write payload are discarded by design.
  logic unused_inputs;
  assign unused_inputs = ^{master.clk, master.rstn,
                           master.aw_addr, master.aw_len, master.aw_size, master.aw_burst,
                           master.aw_lock, master.aw_cache, master.aw_prot, master.aw_qos,
                           master.aw_region, master.aw_user,
                           master.w_data, master.w_strb, master.w_user,
                           master.ar_addr, master.ar_size, master.ar_burst, master.ar_lock,
                           master.ar_cache, master.ar_prot, master.ar_qos, master.ar_region,
                           master.ar_user};
endmodule
